meissa_controller: RTL and testbench

- Sequencer for the MEISSA multiplier array: runs one K-vector multiply job per start request.
- Drives the 3-bit mode bus broadcast to every processing element.
- Issues feed strobes and vector indices to the operand fetch/skew logic.
- Issues accumulate strobes and indices to the downstream adder tree.
- Sits between the PCA top-level control and the array/adder-tree datapath.

---
 rtl/meissa_controller.sv | 144 ++++++++++++++
 tb/tb_meissa_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/meissa_controller.sv
// Job sequencer for the MEISSA multiplier array: steps the PE mode bus, the operand
// feed strobes and the adder-tree accumulate strobes through one K-vector job.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start, all outputs low
// LOAD      | array filling, c < K and c < D (mode 001)
// PROC_LOAD | feeding while products emerge, D <= c < K (mode 010)
// OUT_PROC  | feed finished, draining, K <= c <= K+D-2 (mode 011)
// OUT       | last product, c = K+D-1 (mode 100)
// FIN       | one-cycle done pulse, then back to IDLE
module meissa_controller #(
    parameter int ARRAY_DIM = 4,
    parameter int KW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [2:0]    mode,
    output logic          feed_en,
    output logic [KW-1:0] feed_idx,
    output logic          acc_clear,
    output logic          out_valid,
    output logic [KW-1:0] out_idx
);

    localparam int D  = 2 * ARRAY_DIM - 1;
    localparam int DW = $clog2(D + 1);
    localparam int CW = ((KW > DW) ? KW : DW) + 1;
    localparam logic [CW-1:0] D_C = CW'(D);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        PROC_LOAD = 3'd2,
        OUT_PROC  = 3'd3,
        OUT       = 3'd4,
        FIN       = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [KW-1:0]   k_q, k_n;
    logic [CW-1:0]   k_ext, end_c;

    logic            busy_n, done_n, feed_en_n, acc_clear_n, out_valid_n;
    logic [2:0]      mode_n;
    logic [KW-1:0]   feed_idx_n, out_idx_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        k_n     = k_q;
        case (state)
            IDLE: begin
                if (start) begin
                    k_n     = k_len;
                    cnt_n   = '0;
                    state_n = (k_len == '0) ? FIN : LOAD;
                end
            end
            FIN: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
            default: begin
                if (abort) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
        endcase

        k_ext = CW'(k_n);
        end_c = k_ext + D_C;

        // State by counter position; only recomputed while the job advances.
        if (state != IDLE && state != FIN && !abort) begin
            if (cnt_n == end_c)
                state_n = FIN;
            else if (cnt_n == end_c - CW'(1))
                state_n = OUT;
            else if (cnt_n >= k_ext)
                state_n = OUT_PROC;
            else if (cnt_n >= D_C)
                state_n = PROC_LOAD;
            else
                state_n = LOAD;
        end

        busy_n = (state_n == LOAD) || (state_n == PROC_LOAD) ||
                 (state_n == OUT_PROC) || (state_n == OUT);
        done_n = (state_n == FIN);

        case (state_n)
            LOAD:      mode_n = 3'b001;
            PROC_LOAD: mode_n = 3'b010;
            OUT_PROC:  mode_n = 3'b011;
            OUT:       mode_n = 3'b100;
            default:   mode_n = 3'b000;
        endcase

        feed_en_n   = busy_n && (cnt_n < k_ext);
        feed_idx_n  = feed_en_n ? cnt_n[KW-1:0] : '0;
        acc_clear_n = busy_n && (cnt_n == '0);
        out_valid_n = busy_n && (cnt_n >= D_C) && (cnt_n < end_c);
        out_idx_n   = out_valid_n ? KW'(cnt_n - D_C) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            k_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode      <= 3'b000;
            feed_en   <= 1'b0;
            feed_idx  <= '0;
            acc_clear <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            k_q       <= k_n;
            busy      <= busy_n;
            done      <= done_n;
            mode      <= mode_n;
            feed_en   <= feed_en_n;
            feed_idx  <= feed_idx_n;
            acc_clear <= acc_clear_n;
            out_valid <= out_valid_n;
            out_idx   <= out_idx_n;
        end
    end

endmodule

// File: tb/tb_meissa_controller.sv
// Directed bench for meissa_controller: per-cycle mode/busy/done checks plus a
// scoreboard of expected feed and output indices consumed by a strobe monitor.
module tb_meissa_controller;

    localparam int ARRAY_DIM = 4;
    localparam int KW        = 8;
    localparam int D         = 2 * ARRAY_DIM - 1;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [KW-1:0] k_len;
    logic          busy, done, feed_en, acc_clear, out_valid;
    logic [2:0]    mode;
    logic [KW-1:0] feed_idx, out_idx;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;
    int exp_feed[$];
    int exp_out[$];

    meissa_controller #(.ARRAY_DIM(ARRAY_DIM), .KW(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .done(done), .mode(mode), .feed_en(feed_en),
        .feed_idx(feed_idx), .acc_clear(acc_clear), .out_valid(out_valid),
        .out_idx(out_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] exp_mode(input int c, input int k);
        if (k == 0 || c >= k + D) return 3'b000;
        if (c < k && c < D)       return 3'b001;
        if (c < k)                return 3'b010;
        if (c <= k + D - 2)       return 3'b011;
        return 3'b100;
    endfunction

    // Strobe monitor: every feed/out beat must match the next scoreboard entry.
    always @(negedge clk) begin
        if (mon_on) begin
            if (feed_en === 1'b1) begin
                if (exp_feed.size() == 0) chk("feed_unexpected", 32'(feed_en), 32'd0);
                else chk("feed_idx", 32'(feed_idx), 32'(exp_feed.pop_front()));
            end else begin
                chk("feed_idx_idle", 32'(feed_idx), 32'd0);
            end
            if (out_valid === 1'b1) begin
                if (exp_out.size() == 0) chk("out_unexpected", 32'(out_valid), 32'd0);
                else chk("out_idx", 32'(out_idx), 32'(exp_out.pop_front()));
            end else begin
                chk("out_idx_idle", 32'(out_idx), 32'd0);
            end
        end
    end

    task automatic check_quiet(input string tag);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_feed_en"}, 32'(feed_en), 32'd0);
        chk({tag, "_acc_clear"}, 32'(acc_clear), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // stop_kind: 0 = run to completion, 1 = abort at stop_c, 2 = reset at stop_c.
    // spurious_c: cycle at which a stray start is pulsed (-1 for none).
    task automatic run_job(input int k, input int stop_c, input int stop_kind,
                           input int spurious_c, input bit abort_with_start);
        int fin_c;
        int last;
        fin_c = (k == 0) ? 0 : k + D;
        last  = (stop_kind != 0) ? stop_c : fin_c;
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        abort = abort_with_start;
        for (int c = 0; c <= last; c++) begin
            if (c < k) exp_feed.push_back(c);
            if (k > 0 && c >= D && c <= k + D - 1) exp_out.push_back(c - D);
            @(negedge clk);
            start = (c == spurious_c);
            k_len = (c == spurious_c) ? KW'(5) : KW'(k + 3);
            abort = (stop_kind == 1 && c == stop_c);
            rst   = (stop_kind == 2 && c == stop_c);
            chk($sformatf("mode_k%0d_c%0d", k, c), 32'(mode), 32'(exp_mode(c, k)));
            chk($sformatf("busy_k%0d_c%0d", k, c), 32'(busy), 32'(k > 0 && c < fin_c));
            chk($sformatf("done_k%0d_c%0d", k, c), 32'(done), 32'(c == fin_c));
            chk($sformatf("acc_clear_k%0d_c%0d", k, c), 32'(acc_clear), 32'(k > 0 && c == 0));
        end
        if (stop_kind != 0) begin
            @(negedge clk);
            abort = 1'b0;
            rst   = 1'b0;
            check_quiet($sformatf("stop%0d_k%0d", stop_kind, k));
            repeat (3) begin
                @(negedge clk);
                chk("no_done_after_stop", 32'(done), 32'd0);
                chk("no_busy_after_stop", 32'(busy), 32'd0);
            end
        end
        chk($sformatf("feed_left_k%0d", k), 32'(exp_feed.size()), 32'd0);
        chk($sformatf("out_left_k%0d", k), 32'(exp_out.size()), 32'd0);
        exp_feed.delete();
        exp_out.delete();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        k_len = '0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle");
        mon_on = 1'b1;

        run_job(10, -1, 0, -1, 1'b0);
        run_job(3, -1, 0, -1, 1'b0);
        run_job(0, -1, 0, -1, 1'b0);
        @(negedge clk);
        check_quiet("after_k0");

        run_job(20, 5, 1, -1, 1'b0);
        run_job(2, -1, 0, -1, 1'b0);

        run_job(20, 12, 2, -1, 1'b0);
        run_job(10, -1, 0, 4, 1'b0);

        run_job(1, -1, 0, -1, 1'b0);
        run_job(1, -1, 0, -1, 1'b0);

        run_job(4, -1, 0, -1, 1'b1);

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_quiet("abort_in_idle");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
